// File: rtl/decode_stage.sv
// RV64I decode stage: decodes the fetched word, drives the register-file read
// addresses and holds one ID/EX slot, inserting a single bubble on load-use.
module decode_stage #(
   parameter int XLEN      = 64,
   parameter bit HAZARD_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   input  logic            flush,
   output logic [4:0]      read_register_1,
   output logic [4:0]      read_register_2,
   input  logic [XLEN-1:0] read_data_1,
   input  logic [XLEN-1:0] read_data_2,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [6:0]      ex_opcode,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7_b5,
   output logic            ex_reg_write,
   output logic            ex_illegal
);

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP32    = 7'b0111011;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic            funct7_b5;
      logic            reg_write;
      logic            illegal;
   } slot_t;

   slot_t           slot_q, slot_d;
   logic            valid_q, valid_d;

   logic [6:0]      opc;
   logic [4:0]      rs1_idx, rs2_idx, rd_idx;
   logic [XLEN-1:0] imm;
   logic            legal, uses_rs1, uses_rs2, writes_rd, hazard, accept;

   assign opc     = if_instr[6:0];
   assign rs1_idx = if_instr[19:15];
   assign rs2_idx = if_instr[24:20];
   assign rd_idx  = if_instr[11:7];

   assign read_register_1 = rs1_idx;
   assign read_register_2 = rs2_idx;

   // The opcode includes instr[1:0], so any non-11 low bits fall to default.
   always_comb begin
      imm       = '0;
      legal     = 1'b1;
      uses_rs2  = 1'b0;
      writes_rd = 1'b0;
      case (opc)
         OPC_LUI, OPC_AUIPC: begin
            imm       = {{(XLEN-32){if_instr[31]}}, if_instr[31:12], 12'b0};
            writes_rd = 1'b1;
         end
         OPC_JAL: begin
            imm       = {{(XLEN-20){if_instr[31]}}, if_instr[19:12], if_instr[20],
                         if_instr[30:21], 1'b0};
            writes_rd = 1'b1;
         end
         OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OPIMM32: begin
            imm       = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
            writes_rd = 1'b1;
         end
         OPC_STORE: begin
            imm      = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            uses_rs2 = 1'b1;
         end
         OPC_BRANCH: begin
            imm      = {{(XLEN-12){if_instr[31]}}, if_instr[7], if_instr[30:25],
                        if_instr[11:8], 1'b0};
            uses_rs2 = 1'b1;
         end
         OPC_OP, OPC_OP32: begin
            uses_rs2  = 1'b1;
            writes_rd = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

   assign uses_rs1 = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);

   assign hazard = HAZARD_EN && valid_q && (slot_q.opcode == OPC_LOAD) &&
                   (slot_q.rd != 5'd0) &&
                   ((uses_rs1 && rs1_idx == slot_q.rd) || (uses_rs2 && rs2_idx == slot_q.rd));

   assign if_ready = (!valid_q || ex_ready) && !hazard && !flush;
   assign accept   = if_valid && if_ready;

   always_comb begin
      slot_d  = slot_q;
      valid_d = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d          = 1'b1;
         slot_d.pc        = if_pc;
         slot_d.rs1_data  = read_data_1;
         slot_d.rs2_data  = read_data_2;
         slot_d.imm       = imm;
         slot_d.rs1       = rs1_idx;
         slot_d.rs2       = rs2_idx;
         slot_d.rd        = rd_idx;
         slot_d.opcode    = opc;
         slot_d.funct3    = if_instr[14:12];
         slot_d.funct7_b5 = if_instr[30];
         slot_d.reg_write = writes_rd && (rd_idx != 5'd0);
         slot_d.illegal   = !legal;
      end else if (ex_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         slot_q  <= '0;
      end else begin
         valid_q <= valid_d;
         slot_q  <= slot_d;
      end
   end

   assign ex_valid     = valid_q;
   assign ex_pc        = slot_q.pc;
   assign ex_rs1_data  = slot_q.rs1_data;
   assign ex_rs2_data  = slot_q.rs2_data;
   assign ex_imm       = slot_q.imm;
   assign ex_rs1       = slot_q.rs1;
   assign ex_rs2       = slot_q.rs2;
   assign ex_rd        = slot_q.rd;
   assign ex_opcode    = slot_q.opcode;
   assign ex_funct3    = slot_q.funct3;
   assign ex_funct7_b5 = slot_q.funct7_b5;
   assign ex_reg_write = slot_q.reg_write;
   assign ex_illegal   = slot_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then random traffic, all checked
// against an instruction-level model of the ID/EX slot.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_valid = 1'b0;
   logic        if_ready;
   logic [31:0] if_instr = '0;
   logic [63:0] if_pc = '0;
   logic        flush = 1'b0;
   logic [4:0]  read_register_1, read_register_2;
   logic [63:0] read_data_1 = '0, read_data_2 = '0;
   logic        ex_valid;
   logic        ex_ready = 1'b0;
   logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic        ex_funct7_b5, ex_reg_write, ex_illegal;

   decode_stage #(.XLEN(64), .HAZARD_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
      .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
      .read_register_1(read_register_1), .read_register_2(read_register_2),
      .read_data_1(read_data_1), .read_data_2(read_data_2),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
      .ex_funct3(ex_funct3), .ex_funct7_b5(ex_funct7_b5),
      .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Instruction-level reference: what the slot should hold, as the captured word.
   bit          m_v = 1'b0;
   logic [31:0] m_ins = '0;
   logic [63:0] m_pc = '0, m_d1 = '0, m_d2 = '0;

   function automatic string fmt_of(input logic [6:0] op);
      case (op)
         7'h37, 7'h17:               return "U";
         7'h6F:                      return "J";
         7'h67, 7'h03, 7'h13, 7'h1B: return "I";
         7'h23:                      return "S";
         7'h63:                      return "B";
         7'h33, 7'h3B:               return "R";
         default:                    return "X";
      endcase
   endfunction

   function automatic bit writes(input logic [6:0] op);
      string f = fmt_of(op);
      return (f == "U" || f == "J" || f == "I" || f == "R");
   endfunction

   function automatic bit use1(input logic [6:0] op);
      return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
   endfunction

   function automatic bit use2(input logic [6:0] op);
      string f = fmt_of(op);
      return (f == "S" || f == "B" || f == "R");
   endfunction

   function automatic logic [63:0] ref_imm(input logic [31:0] ins);
      longint li = longint'($signed(ins));
      case (fmt_of(ins[6:0]))
         "I": return li >>> 20;
         "S": return ((li >>> 25) << 5) | longint'(ins[11:7]);
         "B": return ((li >>> 31) << 12) | (longint'(ins[7]) << 11) |
                     (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
         "U": return li & ~64'hFFF;
         "J": return ((li >>> 31) << 20) | (longint'(ins[19:12]) << 12) |
                     (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
         default: return 64'd0;
      endcase
   endfunction

   function automatic bit ref_ready(input logic [31:0] ins, input bit fl, input bit er);
      logic [4:0] rd = m_ins[11:7];
      bit haz = m_v && m_ins[6:0] == 7'h03 && rd != 0 &&
                ((use1(ins[6:0]) && ins[19:15] == rd) || (use2(ins[6:0]) && ins[24:20] == rd));
      return (!m_v || er) && !haz && !fl;
   endfunction

   task automatic check_slot();
      chk("ex_valid", ex_valid, m_v);
      if (m_v) begin
         chk("ex_pc", ex_pc, m_pc);
         chk("ex_rs1_data", ex_rs1_data, m_d1);
         chk("ex_rs2_data", ex_rs2_data, m_d2);
         chk("ex_imm", ex_imm, ref_imm(m_ins));
         chk("ex_regs", {ex_rs1, ex_rs2, ex_rd}, {m_ins[19:15], m_ins[24:20], m_ins[11:7]});
         chk("ex_fields", {ex_opcode, ex_funct3, ex_funct7_b5}, {m_ins[6:0], m_ins[14:12], m_ins[30]});
         chk("ex_reg_write", ex_reg_write, writes(m_ins[6:0]) && m_ins[11:7] != 0);
         chk("ex_illegal", ex_illegal, fmt_of(m_ins[6:0]) == "X");
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, ex_valid, 0);
      chk({tag, "_pc"}, ex_pc, 0);
      chk({tag, "_data"}, ex_rs1_data | ex_rs2_data, 0);
      chk({tag, "_imm"}, ex_imm, 0);
      chk({tag, "_ctl"}, {ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7_b5,
                          ex_reg_write, ex_illegal}, 0);
   endtask

   // One clock, entered and left at the falling edge.
   task automatic cyc(input bit v, input logic [31:0] ins, input bit fl, input bit er);
      bit exp_rdy;
      if_valid = v; if_instr = ins; flush = fl; ex_ready = er;
      if_pc = if_pc + 64'd4;
      #1;
      exp_rdy = ref_ready(ins, fl, er);
      chk("if_ready", if_ready, exp_rdy);
      chk("read_regs", {read_register_1, read_register_2}, {ins[19:15], ins[24:20]});
      @(posedge clk);
      if (fl) m_v = 1'b0;
      else if (v && exp_rdy) begin
         m_v = 1'b1; m_ins = ins; m_pc = if_pc; m_d1 = read_data_1; m_d2 = read_data_2;
      end else if (er) m_v = 1'b0;
      @(negedge clk);
      check_slot();
   endtask

   logic [6:0] opcs [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h03,
                             7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B};

   initial begin
      logic [31:0] ins;
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // addi x5,x10,-1
      read_data_1 = 64'd15; read_data_2 = 64'h1234;
      cyc(1, 32'hFFF50293, 0, 1);
      chk("t1_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t1_rs1_data", ex_rs1_data, 64'd15);
      chk("t1_idx", {ex_rs1, ex_rd, ex_reg_write}, {5'd10, 5'd5, 1'b1});

      // backpressure for three cycles, then accept
      read_data_1 = 64'hAAAA; read_data_2 = 64'hBBBB;
      repeat (3) cyc(1, 32'h00300393, 0, 0);
      chk("t2_held_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      cyc(1, 32'h00300393, 0, 1);
      chk("t2_accept", {ex_rd, ex_imm[7:0]}, {5'd7, 8'd3});

      // load-use: exactly one bubble
      cyc(1, 32'h0000BA03, 0, 1);
      cyc(1, 32'h00AA0333, 0, 1);
      chk("t3_bubble", ex_valid, 0);
      cyc(1, 32'h00AA0333, 0, 1);
      chk("t3_add", {ex_valid, ex_rd}, {1'b1, 5'd6});

      // flush beats a pending capture
      cyc(1, 32'h00300393, 1, 0);
      chk("t4_flush", ex_valid, 0);

      cyc(1, 32'h0000007F, 0, 1);
      chk("t5_illegal", {ex_valid, ex_illegal, ex_reg_write}, 3'b110);
      cyc(1, 32'h00208033, 0, 1);
      chk("t5_x0", {ex_illegal, ex_reg_write}, 2'b00);

      // asynchronous reset in the middle of a stall
      cyc(1, 32'hFFF50293, 0, 1);
      cyc(1, 32'h00300393, 0, 0);
      #2 rst_n = 1'b0;
      #1 check_zero("async_rst");
      m_v = 1'b0; m_ins = '0; m_pc = '0; m_d1 = '0; m_d2 = '0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1, 32'h00300393, 0, 1);
      chk("t6_after", {ex_valid, ex_rd}, {1'b1, 5'd7});

      for (int i = 0; i < 400; i++) begin
         ins = $urandom;
         ins[6:0]   = ($urandom_range(0, 15) == 0) ? 7'($urandom) : opcs[$urandom_range(0, 11)];
         ins[19:15] = 5'($urandom_range(0, 3));
         ins[24:20] = 5'($urandom_range(0, 3));
         ins[11:7]  = 5'($urandom_range(0, 3));
         read_data_1 = {$urandom, $urandom};
         read_data_2 = {$urandom, $urandom};
         cyc($urandom_range(0, 3) != 0, ins, $urandom_range(0, 19) == 0,
             $urandom_range(0, 9) < 7);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
